// File: rtl/lab_pkg.sv
// Shared definitions for the drawing subsystem.
//   draw_seq_state_t : sequencer FSM states
//   SCREEN_W/H       : frame dimensions in pixels
//   colour constants : 3-bit RGB palette
//   sat_inc_count    : saturating increment for the 15-bit plot counter
package lab_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } draw_seq_state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    localparam logic [14:0] PLOT_COUNT_MAX = 15'h7FFF;

    // Holds at the maximum instead of wrapping to zero.
    function automatic logic [14:0] sat_inc_count(input logic [14:0] value);
        if (value == PLOT_COUNT_MAX) begin
            return value;
        end
        return value + 15'd1;
    endfunction

endpackage

// File: rtl/draw_plot_mux.sv
// State-selected VGA plot multiplexer.
//   state              : sequencer state (CLEAR selects fill, DRAW selects shape)
//   fill_vga_*         : fill engine plot outputs
//   shape_vga_*        : triangle engine plot outputs
//   vga_*              : forwarded plot port; all zero in IDLE/DONE
// Purely combinational so the VGA port sees engine outputs with no added latency.
module draw_plot_mux
    import lab_pkg::*;
(
    input  logic [1:0] state,
    input  logic [7:0] fill_vga_x,
    input  logic [6:0] fill_vga_y,
    input  logic [2:0] fill_vga_colour,
    input  logic       fill_vga_plot,
    input  logic [7:0] shape_vga_x,
    input  logic [6:0] shape_vga_y,
    input  logic [2:0] shape_vga_colour,
    input  logic       shape_vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    always_comb begin
        vga_x      = 8'd0;
        vga_y      = 7'd0;
        vga_colour = 3'd0;
        vga_plot   = 1'b0;
        case (state)
            CLEAR: begin
                vga_x      = fill_vga_x;
                vga_y      = fill_vga_y;
                vga_colour = fill_vga_colour;
                vga_plot   = fill_vga_plot;
            end
            DRAW: begin
                vga_x      = shape_vga_x;
                vga_y      = shape_vga_y;
                vga_colour = shape_vga_colour;
                vga_plot   = shape_vga_plot;
            end
            default: begin
                // IDLE/DONE: the port is gated off entirely.
            end
        endcase
    end

endmodule

// File: rtl/draw_sequencer.sv
// Sequences the screen-fill engine and the Reuleaux-triangle engine behind a
// single start/done request and shares the VGA plot port between them.
//   clk, rst_n            : clock, synchronous active-low reset
//   start/done/busy       : request handshake (start held until done seen)
//   clear_en, colour,
//   centre_x/y, diameter  : request fields, latched when start is accepted
//   plot_count            : pixels forwarded for the current/last request
//   fill_*                : fill engine handshake and plot inputs
//   shape_*               : triangle engine handshake, parameters and plot inputs
//   vga_*                 : plot port to the VGA adaptor
module draw_sequencer
    import lab_pkg::*;
#(
    parameter logic [2:0] CLEAR_COLOUR = BLACK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear_en,
    input  logic [2:0]  colour,
    input  logic [7:0]  centre_x,
    input  logic [6:0]  centre_y,
    input  logic [7:0]  diameter,
    output logic        done,
    output logic        busy,
    output logic [14:0] plot_count,
    output logic        fill_start,
    output logic [2:0]  fill_colour,
    input  logic        fill_done,
    input  logic [7:0]  fill_vga_x,
    input  logic [6:0]  fill_vga_y,
    input  logic [2:0]  fill_vga_colour,
    input  logic        fill_vga_plot,
    output logic        shape_start,
    output logic [2:0]  shape_colour,
    output logic [7:0]  shape_centre_x,
    output logic [6:0]  shape_centre_y,
    output logic [7:0]  shape_diameter,
    input  logic        shape_done,
    input  logic [7:0]  shape_vga_x,
    input  logic [6:0]  shape_vga_y,
    input  logic [2:0]  shape_vga_colour,
    input  logic        shape_vga_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot
);

    draw_seq_state_t state_reg, state_next;
    logic            accept;
    logic [14:0]     plot_count_reg, plot_count_next;
    logic [2:0]      colour_reg;
    logic [7:0]      centre_x_reg;
    logic [6:0]      centre_y_reg;
    logic [7:0]      diameter_reg;

    // State register, request latches and pixel counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            plot_count_reg <= 15'd0;
            colour_reg     <= 3'd0;
            centre_x_reg   <= 8'd0;
            centre_y_reg   <= 7'd0;
            diameter_reg   <= 8'd0;
        end else begin
            state_reg      <= state_next;
            plot_count_reg <= plot_count_next;
            if (accept) begin
                colour_reg   <= colour;
                centre_x_reg <= centre_x;
                centre_y_reg <= centre_y;
                diameter_reg <= diameter;
            end
        end
    end

    // Next-state and state-decoded outputs. Engine starts and done/busy are
    // decoded from the state register only, so they change exactly one edge
    // after the event that causes them. Each state only listens to its own
    // engine's done, so a stray done from the other engine has no effect.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        fill_start  = 1'b0;
        shape_start = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = clear_en ? CLEAR : DRAW;
                end
            end
            CLEAR: begin
                busy       = 1'b1;
                fill_start = 1'b1;
                if (fill_done) begin
                    state_next = DRAW;
                end
            end
            DRAW: begin
                busy        = 1'b1;
                shape_start = 1'b1;
                if (shape_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A requester that already dropped start gets a single-cycle done.
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counter clears on acceptance; vga_plot is already zero outside
    // CLEAR/DRAW so the count naturally holds in IDLE/DONE.
    always_comb begin
        plot_count_next = plot_count_reg;
        if (accept) begin
            plot_count_next = 15'd0;
        end else if (vga_plot) begin
            plot_count_next = sat_inc_count(plot_count_reg);
        end
    end

    draw_plot_mux u_plot_mux (
        .state            (state_reg),
        .fill_vga_x       (fill_vga_x),
        .fill_vga_y       (fill_vga_y),
        .fill_vga_colour  (fill_vga_colour),
        .fill_vga_plot    (fill_vga_plot),
        .shape_vga_x      (shape_vga_x),
        .shape_vga_y      (shape_vga_y),
        .shape_vga_colour (shape_vga_colour),
        .shape_vga_plot   (shape_vga_plot),
        .vga_x            (vga_x),
        .vga_y            (vga_y),
        .vga_colour       (vga_colour),
        .vga_plot         (vga_plot)
    );

    assign plot_count     = plot_count_reg;
    assign fill_colour    = CLEAR_COLOUR;
    assign shape_colour   = colour_reg;
    assign shape_centre_x = centre_x_reg;
    assign shape_centre_y = centre_y_reg;
    assign shape_diameter = diameter_reg;

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Top-level controller that sequences the two drawing engines (screen fill and Reuleaux triangle) behind one start/done request and shares the single VGA adaptor plot port between them. On a request it can first clear the 160×120 frame to a fixed colour, then draw the triangle. It sits between the task-level top (switches/keys or testbench driver) and the engines, replacing ad-hoc wiring of engine outputs to the VGA adaptor.

## Interface
- CLEAR_COLOUR, 3'b000, colour used by the fill engine during the clear pass
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; held high by requester until done seen
- clear_en  in  1  1 = run clear pass before drawing; latched with start
- colour  in  3  triangle colour; latched with start
- centre_x  in  8  triangle centre x; latched
- centre_y  in  7  triangle centre y; latched
- diameter  in  8  triangle diameter; latched
- done  out  1  request complete; held while start high
- busy  out  1  high in CLEAR or DRAW
- plot_count  out  15  pixels forwarded to VGA port for current/last request
- fill_start  out  1  fill engine start
- fill_colour  out  3  driven to CLEAR_COLOUR
- fill_done  in  1  fill engine done
- fill_vga_x / fill_vga_y / fill_vga_colour / fill_vga_plot  in  8/7/3/1  fill engine plot outputs
- shape_start  out  1  triangle engine start
- shape_colour / shape_centre_x / shape_centre_y / shape_diameter  out  3/8/7/8  latched request fields
- shape_done  in  1  triangle engine done
- shape_vga_x / shape_vga_y / shape_vga_colour / shape_vga_plot  in  8/7/3/1  triangle engine plot outputs
- vga_x / vga_y / vga_colour / vga_plot  out  8/7/3/1  to VGA adaptor

## Operation
- States: IDLE, CLEAR, DRAW, DONE.
- IDLE: start=1 at clock edge → latch all request fields, clear plot_count to 0; next state CLEAR if clear_en else DRAW.
- CLEAR: fill_start=1 (registered, held). fill_done=1 sampled → DRAW.
- DRAW: shape_start=1 (registered, held). shape_done=1 sampled → DONE.
- DONE: done=1. start=0 sampled → IDLE. start still 1 → stay DONE (no re-trigger).
- Engine start handshake: each engine start stays high until its done is seen, then drops; engines return to idle on start low.
- Plot mux: CLEAR forwards fill_vga_*; DRAW forwards shape_vga_*; IDLE/DONE force vga_plot=0, vga_x/y/colour=0. Plot from the unselected engine is discarded.
- plot_count increments by 1 on every cycle vga_plot=1; saturates at 32767; holds value in IDLE/DONE until next accepted start.
- Request input changes after acceptance are ignored.
- start dropped during CLEAR/DRAW (protocol violation): operation completes; DONE lasts exactly one cycle then IDLE.
- rst_n=0: state IDLE; done, busy, fill_start, shape_start, plot_count, latched fields all 0; vga outputs 0 next cycle.

## Timing
- Reset value of every output 0 (fill_colour = CLEAR_COLOUR constant).
- Start accepted at edge N → busy=1 and fill_start (or shape_start) =1 from N+1.
- fill_done seen at edge M → fill_start=0, shape_start=1 from M+1 (one cycle gap, no overlap).
- shape_done seen at edge K → shape_start=0, done=1 from K+1.
- start=0 seen at edge D in DONE → done=0 from D+1; new start accepted earliest at D+1.
- vga_* outputs are combinational from engine outputs and registered state; zero added latency.
- fill_done and shape_done both high simultaneously: only the done of the current state's engine acts.

## Structure
- lab_pkg: draw_seq_state_t enum {IDLE, CLEAR, DRAW, DONE}; SCREEN_W=160, SCREEN_H=120; colour constants incl. BLACK=3'b000.
- One sub-module: draw_plot_mux (state-selected combinational VGA mux with idle gating).
- FSM, latches and plot_count in draw_sequencer.

## Test plan
- clear_en=1, colour=3'b010, centre (80,60), diameter 80 → 19200 fill plots then triangle plots only from shape engine; done after shape_done; plot_count = 19200 + triangle pixel count.
- clear_en=0, same geometry → fill_start never asserted; first vga_plot at shape engine's first plot; plot_count = triangle count.
- Hold start high 20 cycles after done → done stays 1, no second run; drop start → done=0 next cycle, busy=0.
- Change centre_x 80→10 and colour mid-DRAW → shape_centre_x stays 80, shape_colour unchanged.
- rst_n=0 one cycle mid-CLEAR (after ~5000 plots) → next cycle state IDLE, fill_start=0, vga_plot=0, plot_count=0.
- Stub engines assert fill_plot and shape_plot every cycle → vga_plot matches only selected engine; 0 in IDLE/DONE.
